// File: rtl/mc_cu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, ALU codes,
// datapath mux selects, MIPS opcode/func values and the decoded instruction class.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_HAMD = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [1:0] ASRC_PC     = 2'b00;
    localparam logic [1:0] ASRC_A      = 2'b01;
    localparam logic [1:0] ASRC_SHAMT  = 2'b10;
    localparam logic [1:0] BSRC_B      = 2'b00;
    localparam logic [1:0] BSRC_4      = 2'b01;
    localparam logic [1:0] BSRC_IMM    = 2'b10;
    localparam logic [1:0] BSRC_IMM_SH = 2'b11;
    localparam logic [1:0] PC_ALU      = 2'b00;
    localparam logic [1:0] PC_ALUOUT   = 2'b01;
    localparam logic [1:0] PC_A        = 2'b10;
    localparam logic [1:0] PC_JUMP     = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_HAMD = 6'b000001;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;

    // One-hot instruction class; all zero for an undecodable instruction.
    typedef struct packed {
        logic r_alu;
        logic r_shift;
        logic i_alu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
    } inst_cls_t;

endpackage

// File: rtl/mc_cu_dec.sv
// Combinational instruction decoder: op/func to instruction class, ALU code,
// EXE-phase immediate extension and an illegal-instruction flag.
module mc_cu_dec
    import mc_cu_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output inst_cls_t  cls_o,
    output logic [3:0] aluc_o,
    output logic       sext_o,
    output logic       illegal_o
);

    always_comb begin
        cls_o     = '0;
        aluc_o    = ALU_ADD;
        sext_o    = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    F_ADD:   begin cls_o.r_alu   = 1'b1; aluc_o = ALU_ADD;  end
                    F_SUB:   begin cls_o.r_alu   = 1'b1; aluc_o = ALU_SUB;  end
                    F_AND:   begin cls_o.r_alu   = 1'b1; aluc_o = ALU_AND;  end
                    F_OR:    begin cls_o.r_alu   = 1'b1; aluc_o = ALU_OR;   end
                    F_XOR:   begin cls_o.r_alu   = 1'b1; aluc_o = ALU_XOR;  end
                    F_HAMD:  begin cls_o.r_alu   = 1'b1; aluc_o = ALU_HAMD; end
                    F_SLL:   begin cls_o.r_shift = 1'b1; aluc_o = ALU_SLL;  end
                    F_SRL:   begin cls_o.r_shift = 1'b1; aluc_o = ALU_SRL;  end
                    F_SRA:   begin cls_o.r_shift = 1'b1; aluc_o = ALU_SRA;  end
                    F_JR:    cls_o.jr = 1'b1;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: begin cls_o.i_alu = 1'b1; aluc_o = ALU_ADD; sext_o = 1'b1; end
            OP_ANDI: begin cls_o.i_alu = 1'b1; aluc_o = ALU_AND; end
            OP_ORI:  begin cls_o.i_alu = 1'b1; aluc_o = ALU_OR;  end
            OP_XORI: begin cls_o.i_alu = 1'b1; aluc_o = ALU_XOR; end
            OP_LUI:  begin cls_o.i_alu = 1'b1; aluc_o = ALU_LUI; end
            OP_LW:   begin cls_o.lw    = 1'b1; aluc_o = ALU_ADD; sext_o = 1'b1; end
            OP_SW:   begin cls_o.sw    = 1'b1; aluc_o = ALU_ADD; sext_o = 1'b1; end
            OP_BEQ:  begin cls_o.beq   = 1'b1; aluc_o = ALU_SUB; end
            OP_BNE:  begin cls_o.bne   = 1'b1; aluc_o = ALU_SUB; end
            OP_J:    cls_o.j   = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencing over a shared ALU and a
// unified memory port, with a watchdog bounding every memory wait.
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       wmem,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsource,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic       sext,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    state_t          state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic            mem_err_q, mem_err_d;
    logic            waiting, timeout;

    inst_cls_t  cls;
    logic [3:0] dec_aluc;
    logic       dec_sext;
    logic       dec_illegal;

    mc_cu_dec u_dec (
        .op_i      (op),
        .func_i    (func),
        .cls_o     (cls),
        .aluc_o    (dec_aluc),
        .sext_o    (dec_sext),
        .illegal_o (dec_illegal)
    );

    // Timeout fires on the WAIT_MAX-th consecutive stalled cycle of one visit.
    assign waiting   = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
    assign timeout   = waiting && (wcnt_q == WAIT_LAST);
    assign wcnt_d    = (waiting && !timeout) ? wcnt_q + 1'b1 : '0;
    assign mem_err_d = mem_err_q | timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IF;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iord     = 1'b0;
        wmem     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsource = PC_ALU;
        alusrca  = ASRC_PC;
        alusrcb  = BSRC_B;
        aluc     = ALU_ADD;
        sext     = 1'b0;
        wreg     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                alusrcb = BSRC_4;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // ALUOut captures the branch target while the op is decoded.
                alusrcb = BSRC_IMM_SH;
                sext    = 1'b1;
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end else if (cls.j || cls.jal) begin
                    pcwrite  = 1'b1;
                    pcsource = PC_JUMP;
                    wreg     = cls.jal;
                    jal      = cls.jal;
                    state_d  = S_IF;
                end else if (cls.jr) begin
                    pcwrite  = 1'b1;
                    pcsource = PC_A;
                    state_d  = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = cls.r_shift ? ASRC_SHAMT : ASRC_A;
                alusrcb = (cls.i_alu || cls.lw || cls.sw) ? BSRC_IMM : BSRC_B;
                aluc    = dec_aluc;
                sext    = dec_sext;
                if (cls.beq || cls.bne) begin
                    pcsource = PC_ALUOUT;
                    pcwrite  = (cls.beq && z) || (cls.bne && !z);
                    state_d  = S_IF;
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                wmem    = cls.sw;
                if (mem_ready) state_d = cls.lw ? S_WB : S_IF;
            end
            S_WB: begin
                wreg    = 1'b1;
                m2reg   = cls.lw;
                regrt   = !(cls.r_alu || cls.r_shift);
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
        if (timeout) state_d = S_IF;
        if (reset) begin
            mem_req = 1'b0;
            wmem    = 1'b0;
            irwrite = 1'b0;
            pcwrite = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign mem_err = mem_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// Self-checking bench for mc_cu: directed scenarios plus random instruction
// streams, compared each cycle against an instruction-level reference model.
module tb_mc_cu;

    localparam int WAIT_MAX = 255;

    typedef enum int {
        M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_HAMD, M_SLL, M_SRL, M_SRA, M_JR,
        M_ADDI, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE,
        M_J, M_JAL, M_ILL
    } mn_t;

    logic       clock, reset, z, mem_ready;
    logic [5:0] op, func;
    logic       mem_req, iord, wmem, irwrite, pcwrite, sext, wreg, regrt;
    logic       m2reg, jal, illegal, mem_err;
    logic [1:0] pcsource, alusrca, alusrcb;
    logic [3:0] aluc;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // reference model state: phase 0..4 = IF, ID, EXE, MEM, WB
    int   ph;
    int   wcnt_m;
    logic err_m;
    logic to_ev;
    mn_t  cur_m;

    mc_cu #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .wmem(wmem),
        .irwrite(irwrite), .pcwrite(pcwrite), .pcsource(pcsource),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .sext(sext),
        .wreg(wreg), .regrt(regrt), .m2reg(m2reg), .jal(jal),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic is_ialu(mn_t m);
        return (m == M_ADDI) || (m == M_ANDI) || (m == M_ORI) || (m == M_XORI) || (m == M_LUI);
    endfunction

    function automatic logic [3:0] alu_code(mn_t m);
        case (m)
            M_SUB, M_BEQ, M_BNE: return 4'b0100;
            M_AND, M_ANDI:       return 4'b0001;
            M_OR,  M_ORI:        return 4'b0101;
            M_XOR, M_XORI:       return 4'b0010;
            M_SLL:               return 4'b0011;
            M_SRL:               return 4'b0111;
            M_SRA:               return 4'b1111;
            M_LUI:               return 4'b0110;
            M_HAMD:              return 4'b1011;
            default:             return 4'b0000;
        endcase
    endfunction

    function automatic int base_latency(mn_t m);
        case (m)
            M_J, M_JAL, M_JR, M_ILL: return 2;
            M_BEQ, M_BNE:            return 3;
            M_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected control word {mem_req,iord,wmem,irwrite,pcwrite,pcsource,
    // alusrca,alusrcb,aluc,sext,wreg,regrt,m2reg,jal,illegal}.
    function automatic logic [20:0] exp_ctl(int p, mn_t m, logic zz, logic rdy, logic rst);
        logic req = 0, io = 0, wm = 0, irw = 0, pcw = 0, sx = 0, wr = 0, rrt = 0;
        logic m2r = 0, jl = 0, ill = 0;
        logic [1:0] pcs = 0, asa = 0, asb = 0;
        logic [3:0] alu = 0;
        case (p)
            0: begin req = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            1: begin
                asb = 2'd3; sx = 1;
                if (m == M_J || m == M_JAL) begin pcw = 1; pcs = 2'd3; end
                if (m == M_JAL) begin wr = 1; jl = 1; end
                if (m == M_JR) begin pcw = 1; pcs = 2'd2; end
                if (m == M_ILL) ill = 1;
            end
            2: begin
                asa = (m == M_SLL || m == M_SRL || m == M_SRA) ? 2'd2 : 2'd1;
                asb = (is_ialu(m) || m == M_LW || m == M_SW) ? 2'd2 : 2'd0;
                alu = alu_code(m);
                sx  = (m == M_ADDI || m == M_LW || m == M_SW);
                if (m == M_BEQ) begin pcs = 2'd1; pcw = zz; end
                if (m == M_BNE) begin pcs = 2'd1; pcw = !zz; end
            end
            3: begin req = 1; io = 1; wm = (m == M_SW); end
            4: begin wr = 1; m2r = (m == M_LW); rrt = is_ialu(m) || (m == M_LW); end
            default: ;
        endcase
        if (rst) begin req = 0; wm = 0; irw = 0; pcw = 0; wr = 0; ill = 0; end
        return {req, io, wm, irw, pcw, pcs, asa, asb, alu, sx, wr, rrt, m2r, jl, ill};
    endfunction

    task automatic encode(input mn_t m, output logic [5:0] o, output logic [5:0] f);
        o = 6'b000000;
        f = 6'($urandom);
        case (m)
            M_ADD:  f = 6'b100000;
            M_SUB:  f = 6'b100010;
            M_AND:  f = 6'b100100;
            M_OR:   f = 6'b100101;
            M_XOR:  f = 6'b100110;
            M_HAMD: f = 6'b000001;
            M_SLL:  f = 6'b000000;
            M_SRL:  f = 6'b000010;
            M_SRA:  f = 6'b000011;
            M_JR:   f = 6'b001000;
            M_ADDI: o = 6'b001000;
            M_ANDI: o = 6'b001100;
            M_ORI:  o = 6'b001101;
            M_XORI: o = 6'b001110;
            M_LUI:  o = 6'b001111;
            M_LW:   o = 6'b100011;
            M_SW:   o = 6'b101011;
            M_BEQ:  o = 6'b000100;
            M_BNE:  o = 6'b000101;
            M_J:    o = 6'b000010;
            M_JAL:  o = 6'b000011;
            default: begin
                if ($urandom_range(0, 1) == 0) o = 6'b111111;
                else f = 6'b111111;
            end
        endcase
    endtask

    // One clock: inputs held from posedge+1, outputs sampled at posedge+5.
    task automatic tick(input logic rdy, input logic zz);
        logic [20:0] got;
        logic        waiting;
        mem_ready = rdy;
        z = zz;
        #4;
        got = {mem_req, iord, wmem, irwrite, pcwrite, pcsource, alusrca, alusrcb,
               aluc, sext, wreg, regrt, m2reg, jal, illegal};
        chk("ctl", 32'(got), 32'(exp_ctl(ph, cur_m, zz, rdy, reset)));
        chk("state", 32'(state), 32'(ph));
        chk("mem_err", 32'(mem_err), 32'(err_m));
        @(posedge clock);
        to_ev = 1'b0;
        if (reset) begin
            ph = 0; wcnt_m = 0; err_m = 1'b0;
        end else begin
            waiting = (ph == 0 || ph == 3) && !rdy;
            if (waiting) begin
                wcnt_m++;
                if (wcnt_m == WAIT_MAX) begin
                    err_m = 1'b1; ph = 0; wcnt_m = 0; to_ev = 1'b1;
                end
            end else begin
                wcnt_m = 0;
                case (ph)
                    0: ph = 1;
                    1: ph = (cur_m == M_J || cur_m == M_JAL || cur_m == M_JR || cur_m == M_ILL) ? 0 : 2;
                    2: ph = (cur_m == M_BEQ || cur_m == M_BNE) ? 0 :
                            ((cur_m == M_LW || cur_m == M_SW) ? 3 : 4);
                    3: ph = (cur_m == M_LW) ? 4 : 0;
                    default: ph = 0;
                endcase
            end
        end
        #1;
    endtask

    // Run one instruction from IF back to IF, stalling wif cycles in IF and wmem in MEM.
    task automatic run_instr(input mn_t m, input int wif, input int wmw, input logic zz);
        int   cyc = 0, wi = 0, wmc = 0, prev;
        logic done = 0, r, zv, timed_out = 0;
        logic [5:0] o, f;
        cur_m = m;
        encode(m, o, f);
        op = o;
        func = f;
        while (!done && cyc < 1000) begin
            if (ph == 0) begin
                r = (wi >= wif);
                if (!r) wi++;
            end else if (ph == 3) begin
                r = (wmc >= wmw);
                if (!r) wmc++;
            end else begin
                r = 1'($urandom);
            end
            zv = (ph == 2) ? zz : 1'($urandom);
            prev = ph;
            tick(r, zv);
            cyc++;
            if (to_ev) timed_out = 1'b1;
            if (to_ev || (ph == 0 && prev != 0)) done = 1'b1;
        end
        if (!done) chk("cycle_budget", 32'(cyc), 32'd1000 + 32'd1);
        else if (!timed_out)
            chk("latency", 32'(cyc),
                32'(base_latency(m) + wif + ((m == M_LW || m == M_SW) ? wmw : 0)));
    endtask

    initial begin
        reset = 1'b1; op = 6'd0; func = 6'd0; z = 1'b0; mem_ready = 1'b0;
        ph = 0; wcnt_m = 0; err_m = 1'b0; to_ev = 1'b0; cur_m = M_ADD;
        @(posedge clock);
        #1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b0;

        run_instr(M_ADD, 0, 0, 1'b0);
        run_instr(M_LW, 0, 3, 1'b0);
        run_instr(M_BEQ, 0, 0, 1'b1);
        run_instr(M_BNE, 0, 0, 1'b1);
        run_instr(M_JAL, 0, 0, 1'b0);
        run_instr(M_ILL, 0, 0, 1'b0);
        run_instr(M_HAMD, 2, 0, 1'b0);
        run_instr(M_SRA, 0, 0, 1'b0);
        run_instr(M_SW, 1, 2, 1'b0);

        // fetch watchdog: 255 stalled IF cycles, then a clean retry
        run_instr(M_ADD, 400, 0, 1'b0);
        chk("if_timeout_err", 32'(mem_err), 32'd1);
        chk("if_timeout_state", 32'(state), 32'd0);
        run_instr(M_ORI, 0, 0, 1'b0);

        // store watchdog: the sw is abandoned in MEM
        run_instr(M_SW, 0, 400, 1'b0);
        chk("mem_timeout_state", 32'(state), 32'd0);

        // reset in the middle of a stalled sw
        cur_m = M_SW;
        op = 6'b101011;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_wmem", 32'(wmem), 32'd0);

        for (int i = 0; i < 250; i++) begin
            run_instr(mn_t'($urandom_range(0, 21)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
